// File: rtl/oc_pkg.sv
// Shared types and default widths for the operand-collector slot.
package oc_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int WARP_W_DEF = 3;
  localparam int BANK_W     = 2;
  localparam int ROW_W      = 3;
  localparam int REG_W      = 3;
  localparam int OCID_W     = 2;

  typedef enum logic [1:0] {
    OC_EMPTY   = 2'd0,
    OC_COLLECT = 2'd1,
    OC_READY   = 2'd2
  } oc_state_e;

  // One register-file read request as seen by the bank arbiter.
  typedef struct packed {
    logic              valid;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
  } oc_req_t;

endpackage

// File: rtl/operand_collector_unit_if.sv
// Bus bundle of one operand-collector slot: allocation, bank requests,
// read returns and dispatch. The writeback snoop signals exist only when
// OC_WB_BYPASS_EN is defined.
interface operand_collector_unit_if #(
  parameter int DATA_W = oc_pkg::DATA_W_DEF,
  parameter int WARP_W = oc_pkg::WARP_W_DEF
);
  import oc_pkg::*;

  logic                 alloc_valid;
  logic [OCID_W-1:0]    alloc_ocid;
  logic [31:0]          alloc_instr;
  logic [WARP_W-1:0]    alloc_warp;
  logic                 alloc_need_b;
  logic [REG_W-1:0]     alloc_reg_a;
  logic [REG_W-1:0]     alloc_reg_b;
  logic [BANK_W-1:0]    bank_a;
  logic [BANK_W-1:0]    bank_b;
  logic [ROW_W-1:0]     row_a;
  logic [ROW_W-1:0]     row_b;
  logic                 oc_empty;
  logic                 req_a_valid;
  logic [BANK_W-1:0]    req_a_bank;
  logic [ROW_W-1:0]     req_a_row;
  logic                 req_b_valid;
  logic [BANK_W-1:0]    req_b_bank;
  logic [ROW_W-1:0]     req_b_row;
  logic                 gnt_a;
  logic                 gnt_b;
  logic                 rd_a_valid;
  logic [DATA_W-1:0]    rd_a_data;
  logic                 rd_b_valid;
  logic [DATA_W-1:0]    rd_b_data;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [31:0]          disp_instr;
  logic [WARP_W-1:0]    disp_warp;
  logic [DATA_W-1:0]    disp_op_a;
  logic [DATA_W-1:0]    disp_op_b;
`ifdef OC_WB_BYPASS_EN
  logic                 wb_valid;
  logic [WARP_W-1:0]    wb_warp;
  logic [REG_W-1:0]     wb_reg;
  logic [DATA_W-1:0]    wb_data;
`endif

  // Environment side: issue stage, arbiter, register file, execute.
  modport master (
    output alloc_valid, alloc_ocid, alloc_instr, alloc_warp, alloc_need_b,
    output alloc_reg_a, alloc_reg_b, bank_a, bank_b, row_a, row_b,
    output gnt_a, gnt_b, rd_a_valid, rd_a_data, rd_b_valid, rd_b_data, disp_ready,
`ifdef OC_WB_BYPASS_EN
    output wb_valid, wb_warp, wb_reg, wb_data,
`endif
    input  oc_empty, req_a_valid, req_a_bank, req_a_row,
    input  req_b_valid, req_b_bank, req_b_row,
    input  disp_valid, disp_instr, disp_warp, disp_op_a, disp_op_b
  );

  // Collector slot side.
  modport slave (
    input  alloc_valid, alloc_ocid, alloc_instr, alloc_warp, alloc_need_b,
    input  alloc_reg_a, alloc_reg_b, bank_a, bank_b, row_a, row_b,
    input  gnt_a, gnt_b, rd_a_valid, rd_a_data, rd_b_valid, rd_b_data, disp_ready,
`ifdef OC_WB_BYPASS_EN
    input  wb_valid, wb_warp, wb_reg, wb_data,
`endif
    output oc_empty, req_a_valid, req_a_bank, req_a_row,
    output req_b_valid, req_b_bank, req_b_row,
    output disp_valid, disp_instr, disp_warp, disp_op_a, disp_op_b
  );

endinterface

// File: rtl/oc_operand_slot.sv
// One source operand of a collector slot: pending/in-flight tracking, the
// held bank/row request and the captured operand data.
module oc_operand_slot
  import oc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_need,
  input  logic [BANK_W-1:0] load_bank,
  input  logic [ROW_W-1:0]  load_row,
  input  logic              collect,
  input  logic              gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wb_hit,
  input  logic [DATA_W-1:0] wb_data,
  output oc_req_t           req,
  output logic              pend_nxt,
  output logic [DATA_W-1:0] data
);

  logic              pend_r;
  logic              inflight_r;
  logic [DATA_W-1:0] data_r;
  oc_req_t           req_r;

  logic              pend_s;
  logic              inflight_s;
  logic              req_valid_s;
  logic [DATA_W-1:0] data_s;

  // Next operand state; a snooped writeback takes priority over a bank return,
  // and a return is only honoured while a granted read is outstanding.
  always_comb begin
    pend_s     = pend_r;
    inflight_s = inflight_r;
    data_s     = data_r;
    if (load) begin
      pend_s     = load_need;
      inflight_s = 1'b0;
      data_s     = {DATA_W{1'b0}};
    end else if (collect) begin
      if (wb_hit && pend_r) begin
        pend_s     = 1'b0;
        inflight_s = 1'b0;
        data_s     = wb_data;
      end else if (inflight_r && rd_valid) begin
        pend_s     = 1'b0;
        inflight_s = 1'b0;
        data_s     = rd_data;
      end else if (req_r.valid && gnt) begin
        inflight_s = 1'b1;
      end else begin
        inflight_s = inflight_r;
      end
    end else begin
      pend_s = pend_r;
    end
    req_valid_s = pend_s && !inflight_s;
  end

  // Operand state registers; the request address is held from allocation until reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r     <= 1'b0;
      inflight_r <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      req_r.valid <= 1'b0;
      req_r.bank  <= {BANK_W{1'b0}};
      req_r.row   <= {ROW_W{1'b0}};
    end else begin
      pend_r      <= pend_s;
      inflight_r  <= inflight_s;
      data_r      <= data_s;
      req_r.valid <= req_valid_s;
      if (load) begin
        req_r.bank <= load_bank;
        req_r.row  <= load_row;
      end
    end
  end

  assign req      = req_r;
  assign pend_nxt = pend_s;
  assign data     = data_r;

endmodule

// File: rtl/operand_collector_unit.sv
// Operand-collector slot: captures an allocated instruction, gathers up to
// two source operands from the banked register file and dispatches them.
// Optional build macro OC_WB_BYPASS_EN adds a writeback snoop that can
// satisfy a pending operand without a bank read.
module operand_collector_unit
  import oc_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int WARP_W = 3,
  parameter int OC_ID  = 0
) (
  input logic clk,
  input logic rst,
  operand_collector_unit_if.slave bus
);

  localparam logic [OCID_W-1:0] OC_ID_L = OC_ID[OCID_W-1:0];

  oc_state_e         state_r;
  logic              oc_empty_r;
  logic              disp_valid_r;
  logic [31:0]       instr_r;
  logic [WARP_W-1:0] warp_r;

  logic              alloc_hit_s;
  logic              collect_s;
  logic              wb_hit_a_s;
  logic              wb_hit_b_s;
  logic [DATA_W-1:0] wb_data_s;
  logic              pend_a_nxt_s;
  logic              pend_b_nxt_s;
  oc_req_t           req_a_s;
  oc_req_t           req_b_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;

  // Allocation is only taken by this slot while it is free.
  always_comb begin
    if (state_r == OC_EMPTY) begin
      alloc_hit_s = bus.alloc_valid && (bus.alloc_ocid == OC_ID_L);
    end else begin
      alloc_hit_s = 1'b0;
    end
  end

  assign collect_s = (state_r == OC_COLLECT);

`ifdef OC_WB_BYPASS_EN
  logic [REG_W-1:0] reg_a_r;
  logic [REG_W-1:0] reg_b_r;

  // Source register numbers kept for writeback snooping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a_r <= {REG_W{1'b0}};
      reg_b_r <= {REG_W{1'b0}};
    end else if (alloc_hit_s) begin
      reg_a_r <= bus.alloc_reg_a;
      reg_b_r <= bus.alloc_reg_b;
    end
  end

  assign wb_hit_a_s = bus.wb_valid && (bus.wb_warp == warp_r) && (bus.wb_reg == reg_a_r);
  assign wb_hit_b_s = bus.wb_valid && (bus.wb_warp == warp_r) && (bus.wb_reg == reg_b_r);
  assign wb_data_s  = bus.wb_data;
`else
  assign wb_hit_a_s = 1'b0;
  assign wb_hit_b_s = 1'b0;
  assign wb_data_s  = {DATA_W{1'b0}};
`endif

  oc_operand_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (alloc_hit_s),
    .load_need (1'b1),
    .load_bank (bus.bank_a),
    .load_row  (bus.row_a),
    .collect   (collect_s),
    .gnt       (bus.gnt_a),
    .rd_valid  (bus.rd_a_valid),
    .rd_data   (bus.rd_a_data),
    .wb_hit    (wb_hit_a_s),
    .wb_data   (wb_data_s),
    .req       (req_a_s),
    .pend_nxt  (pend_a_nxt_s),
    .data      (op_a_s)
  );

  oc_operand_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (alloc_hit_s),
    .load_need (bus.alloc_need_b),
    .load_bank (bus.bank_b),
    .load_row  (bus.row_b),
    .collect   (collect_s),
    .gnt       (bus.gnt_b),
    .rd_valid  (bus.rd_b_valid),
    .rd_data   (bus.rd_b_data),
    .wb_hit    (wb_hit_b_s),
    .wb_data   (wb_data_s),
    .req       (req_b_s),
    .pend_nxt  (pend_b_nxt_s),
    .data      (op_b_s)
  );

  // Slot FSM: READY is entered on the edge the last operand lands so dispatch
  // follows the final data return by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= OC_EMPTY;
      oc_empty_r   <= 1'b1;
      disp_valid_r <= 1'b0;
      instr_r      <= 32'd0;
      warp_r       <= {WARP_W{1'b0}};
    end else begin
      case (state_r)
        OC_EMPTY: begin
          if (alloc_hit_s) begin
            state_r    <= OC_COLLECT;
            oc_empty_r <= 1'b0;
            instr_r    <= bus.alloc_instr;
            warp_r     <= bus.alloc_warp;
          end
        end
        OC_COLLECT: begin
          if (!pend_a_nxt_s && !pend_b_nxt_s) begin
            state_r      <= OC_READY;
            disp_valid_r <= 1'b1;
          end
        end
        OC_READY: begin
          if (bus.disp_ready) begin
            state_r      <= OC_EMPTY;
            disp_valid_r <= 1'b0;
            oc_empty_r   <= 1'b1;
          end
        end
        default: begin
          state_r      <= OC_EMPTY;
          oc_empty_r   <= 1'b1;
          disp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oc_empty    = oc_empty_r;
  assign bus.req_a_valid = req_a_s.valid;
  assign bus.req_a_bank  = req_a_s.bank;
  assign bus.req_a_row   = req_a_s.row;
  assign bus.req_b_valid = req_b_s.valid;
  assign bus.req_b_bank  = req_b_s.bank;
  assign bus.req_b_row   = req_b_s.row;
  assign bus.disp_valid  = disp_valid_r;
  assign bus.disp_instr  = instr_r;
  assign bus.disp_warp   = warp_r;
  assign bus.disp_op_a   = op_a_s;
  assign bus.disp_op_b   = op_b_s;

endmodule
